// File: rtl/prio_enc_queued_pkg.sv
// Shared types and helpers for the queued priority encoder.
// Round-robin arbitration is selected at build time with PRIO_ENC_ROUND_ROBIN_EN.
package prio_enc_queued_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_e;

    // Number of set bits in a vector of up to 64 request lines.
    function automatic int unsigned popcount(input logic [63:0] v);
        int unsigned c;
        c = 0;
        for (int i = 0; i < 64; i++) begin
            c = c + 32'(v[i]);
        end
        return c;
    endfunction

    // Addition clamped to maxv.
    function automatic int unsigned sat_add(input int unsigned a,
                                            input int unsigned b,
                                            input int unsigned maxv);
        longint unsigned s;
        s = longint'(a) + longint'(b);
        if (s > longint'(maxv)) begin
            return maxv;
        end
        return a + b;
    endfunction

endpackage

// File: rtl/prio_enc_queued_if.sv
// Request/grant bundle between the event lines, the encoder and its consumer.
interface prio_enc_queued_if #(
    parameter int N     = 8,
    parameter int DUP_W = 4
);
    localparam int W = $clog2(N);

    logic [N-1:0]     req;
    logic [W-1:0]     code;
    logic             valid;
    logic             ready;
    logic [N-1:0]     pending;
    logic [DUP_W-1:0] dup_cnt;

    modport master (
        output req, ready,
        input  code, valid, pending, dup_cnt
    );

    modport slave (
        input  req, ready,
        output code, valid, pending, dup_cnt
    );
endinterface

// File: rtl/prio_enc_queued_pick.sv
// Rotated find-first-set: scans vec_i from base_i downward, wrapping at 0 to N-1.
module prio_pick #(
    parameter  int N = 8,
    localparam int W = $clog2(N)
) (
    input  logic [N-1:0] vec_i,
    input  logic [W-1:0] base_i,
    output logic [W-1:0] idx_o,
    output logic         any_o
);

    int p;

    // First set bit encountered walking down from base_i.
    always_comb begin
        idx_o = '0;
        any_o = 1'b0;
        p     = 0;
        for (int k = 0; k < N; k++) begin
            p = int'(base_i) - k;
            if (p < 0) begin
                p = p + N;
            end
            if (!any_o && vec_i[p[W-1:0]]) begin
                any_o = 1'b1;
                idx_o = p[W-1:0];
            end
        end
    end

endmodule

// File: rtl/prio_enc_queued.sv
// Queued N:log2(N) priority encoder with valid/ready output and duplicate counter.
// Build option PRIO_ENC_ROUND_ROBIN_EN: round-robin search starting at (last code+1);
// without it the highest pending index always wins.
module prio_enc_queued
    import prio_enc_queued_pkg::*;
#(
    parameter int N     = 8,
    parameter int DUP_W = 4
) (
    input logic               clk,
    input logic               rst,
    prio_enc_queued_if.slave  bus
);

    localparam int          W       = $clog2(N);
    localparam int unsigned DUP_MAX = (32'd1 << DUP_W) - 32'd1;

    state_e           state_q, state_d;
    logic [W-1:0]     code_q, code_d;
    logic             valid_q, valid_d;
    logic [N-1:0]     pending_q, pending_d;
    logic [DUP_W-1:0] dup_q, dup_d;

    logic [N-1:0]     cand;
    logic [N-1:0]     pick_bit;
    logic [N-1:0]     held_bit;
    logic [N-1:0]     merged;
    logic [W-1:0]     pick;
    logic             any;

    assign cand = pending_q | bus.req;

`ifdef PRIO_ENC_ROUND_ROBIN_EN
    logic [W-1:0] ptr_q, ptr_d;
    logic [N-1:0] cand_rev;
    logic [W-1:0] idx_rev;

    // Upward search from ptr equals downward search on the bit-reversed vector.
    always_comb begin
        cand_rev = '0;
        for (int i = 0; i < N; i++) begin
            cand_rev[i] = cand[N-1-i];
        end
    end

    prio_pick #(.N(N)) u_pick (
        .vec_i  (cand_rev),
        .base_i (W'(N-1) - ptr_q),
        .idx_o  (idx_rev),
        .any_o  (any)
    );

    assign pick = W'(N-1) - idx_rev;

    // Pointer advances past each granted code; a stalled HOLD leaves it alone.
    always_comb begin
        ptr_d = ptr_q;
        if (any && (state_q == IDLE || bus.ready)) begin
            ptr_d = (pick == W'(N-1)) ? '0 : pick + 1'b1;
        end
    end

    // Round-robin pointer register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    prio_pick #(.N(N)) u_pick (
        .vec_i  (cand),
        .base_i (W'(N-1)),
        .idx_o  (pick),
        .any_o  (any)
    );
`endif

    // One-hot views of the new pick and of the code currently presented.
    always_comb begin
        pick_bit       = '0;
        pick_bit[pick] = 1'b1;
        held_bit         = '0;
        held_bit[code_q] = 1'b1;
    end

    // Requests that collapse into something already waiting: a pending bit, or the
    // held code while the consumer is stalling. In a transfer cycle the held code
    // is leaving, so a request on it is a fresh event and gets queued instead.
    always_comb begin
        merged = bus.req & pending_q;
        if (state_q == HOLD && !bus.ready) begin
            merged = merged | (bus.req & held_bit);
        end
        dup_d = DUP_W'(sat_add(32'(dup_q), popcount(64'(merged)), DUP_MAX));
    end

    // Next-state and datapath updates; at most one grant per clock.
    always_comb begin
        state_d   = state_q;
        code_d    = code_q;
        valid_d   = valid_q;
        pending_d = pending_q;
        case (state_q)
            IDLE: begin
                if (any) begin
                    code_d    = pick;
                    valid_d   = 1'b1;
                    pending_d = cand & ~pick_bit;
                    state_d   = HOLD;
                end
            end
            HOLD: begin
                if (!bus.ready) begin
                    pending_d = pending_q | (bus.req & ~held_bit);
                end else if (any) begin
                    code_d    = pick;
                    pending_d = cand & ~pick_bit;
                end else begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Output code, queue and duplicate counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            code_q    <= '0;
            valid_q   <= 1'b0;
            pending_q <= '0;
            dup_q     <= '0;
        end else begin
            code_q    <= code_d;
            valid_q   <= valid_d;
            pending_q <= pending_d;
            dup_q     <= dup_d;
        end
    end

    assign bus.code    = code_q;
    assign bus.valid   = valid_q;
    assign bus.pending = pending_q;
    assign bus.dup_cnt = dup_q;

endmodule

// File: tb/tb_prio_enc_queued.sv
// Directed bench for prio_enc_queued: three instances (N=8/DUP_W=4, N=8/DUP_W=2, N=5).
module tb_prio_enc_queued;

`ifdef PRIO_ENC_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    prio_enc_queued_if #(.N(8), .DUP_W(4)) if_a ();
    prio_enc_queued_if #(.N(8), .DUP_W(2)) if_b ();
    prio_enc_queued_if #(.N(5), .DUP_W(4)) if_c ();

    prio_enc_queued #(.N(8), .DUP_W(4)) dut_a (.clk(clk), .rst(rst), .bus(if_a));
    prio_enc_queued #(.N(8), .DUP_W(2)) dut_b (.clk(clk), .rst(rst), .bus(if_b));
    prio_enc_queued #(.N(5), .DUP_W(4)) dut_c (.clk(clk), .rst(rst), .bus(if_c));

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no end of run, expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        if_a.req = '0; if_a.ready = 1'b0;
        if_b.req = '0; if_b.ready = 1'b0;
        if_c.req = '0; if_c.ready = 1'b0;

        // Reset state
        tick(); tick();
        chk("rst_code",  32'(if_a.code),    0);
        chk("rst_valid", 32'(if_a.valid),   0);
        chk("rst_pend",  32'(if_a.pending), 0);
        chk("rst_dup",   32'(if_a.dup_cnt), 0);
        chk("rst_c_valid", 32'(if_c.valid), 0);
        rst = 1'b0;
        tick();

        // Two requests in one clock, consumer always ready
        if_a.ready = 1'b1;
        if_a.req = 8'h84;
        tick();
        if_a.req = 8'h00;
        chk("t1_valid0", 32'(if_a.valid),   1);
        chk("t1_code0",  32'(if_a.code),    RR ? 2 : 7);
        chk("t1_pend0",  32'(if_a.pending), RR ? 32'h80 : 32'h04);
        tick();
        chk("t1_valid1", 32'(if_a.valid),   1);
        chk("t1_code1",  32'(if_a.code),    RR ? 7 : 2);
        chk("t1_pend1",  32'(if_a.pending), 0);
        tick();
        chk("t1_valid2", 32'(if_a.valid),   0);

        // Stalled consumer: repeated request on the held code merges
        if_a.ready = 1'b0;
        if_a.req = 8'h01;
        tick();
        chk("t2_code",   32'(if_a.code),    0);
        chk("t2_valid",  32'(if_a.valid),   1);
        chk("t2_dup0",   32'(if_a.dup_cnt), 0);
        tick();
        chk("t2_dup1",   32'(if_a.dup_cnt), 1);
        tick();
        chk("t2_dup2",   32'(if_a.dup_cnt), 2);
        chk("t2_code2",  32'(if_a.code),    0);
        chk("t2_pend2",  32'(if_a.pending), 0);
        if_a.req = 8'h00;
        if_a.ready = 1'b1;
        tick();
        chk("t2_drop",   32'(if_a.valid),   0);
        chk("t2_dupkeep",32'(if_a.dup_cnt), 2);

`ifndef PRIO_ENC_ROUND_ROBIN_EN
        // Merge into pending, merge into held code, double merge, requeue on transfer
        if_a.ready = 1'b0;
        if_a.req = 8'h30;
        tick();
        chk("mg_code",   32'(if_a.code),    5);
        chk("mg_pend",   32'(if_a.pending), 32'h10);
        if_a.req = 8'h10;
        tick();
        chk("mg_dup_p",  32'(if_a.dup_cnt), 3);
        chk("mg_pend1",  32'(if_a.pending), 32'h10);
        if_a.req = 8'h20;
        tick();
        chk("mg_dup_c",  32'(if_a.dup_cnt), 4);
        if_a.req = 8'h30;
        tick();
        chk("mg_dup_2",  32'(if_a.dup_cnt), 6);
        if_a.req = 8'h20;
        if_a.ready = 1'b1;
        tick();
        if_a.req = 8'h00;
        chk("mg_rq_code",32'(if_a.code),    5);
        chk("mg_rq_pend",32'(if_a.pending), 32'h10);
        chk("mg_rq_dup", 32'(if_a.dup_cnt), 6);
        tick();
        chk("mg_code4",  32'(if_a.code),    4);
        chk("mg_pend0",  32'(if_a.pending), 0);
        tick();
        chk("mg_idle",   32'(if_a.valid),   0);
`endif

        // Asynchronous reset in the middle of HOLD
        if_a.ready = 1'b0;
        if_a.req = 8'hB0;
        tick();
        if_a.req = 8'h00;
        chk("t5_pre_pend", 32'(if_a.pending), RR ? 32'hA0 : 32'h30);
        chk("t5_pre_valid",32'(if_a.valid),   1);
        #3;
        rst = 1'b1;
        #1;
        chk("t5_valid", 32'(if_a.valid),   0);
        chk("t5_pend",  32'(if_a.pending), 0);
        chk("t5_code",  32'(if_a.code),    0);
        chk("t5_dup",   32'(if_a.dup_cnt), 0);
        tick();
        rst = 1'b0;
        tick();
        chk("t5_idle",  32'(if_a.valid),   0);
        if_a.ready = 1'b1;
        if_a.req = 8'h80;
        tick();
        if_a.req = 8'h00;
        chk("t5_again_v", 32'(if_a.valid), 1);
        chk("t5_again_c", 32'(if_a.code),  7);
        tick();
        chk("t5_again_idle", 32'(if_a.valid), 0);

        // All lines at once: one grant per clock
        if_a.req = 8'hFF;
        tick();
        if_a.req = 8'h00;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("t3_code%0d", i), 32'(if_a.code), RR ? i : 7 - i);
            chk($sformatf("t3_valid%0d", i), 32'(if_a.valid), 1);
            tick();
        end
        chk("t3_end", 32'(if_a.valid), 0);

        // Duplicate counter saturation with a 2-bit counter
        if_b.ready = 1'b0;
        if_b.req = 8'h88;
        tick();
        chk("t4_valid", 32'(if_b.valid),   1);
        chk("t4_dup0",  32'(if_b.dup_cnt), 0);
        if_b.req = 8'h08;
        for (int i = 1; i <= 5; i++) begin
            tick();
            chk($sformatf("t4_dup%0d", i), 32'(if_b.dup_cnt), (i > 3) ? 3 : i);
        end
        if_b.req = 8'h00;

        // N=5: codes stay within 0..4
        if_c.ready = 1'b1;
        if_c.req = 5'b10001;
        tick();
        if_c.req = 5'b00000;
        chk("t6_code0", 32'(if_c.code), RR ? 0 : 4);
        tick();
        chk("t6_code1", 32'(if_c.code), RR ? 4 : 0);
        tick();
        chk("t6_idle",  32'(if_c.valid), 0);
        if_c.req = 5'b11111;
        tick();
        if_c.req = 5'b00000;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("t6_all%0d", i), 32'(if_c.code), RR ? i : 4 - i);
            tick();
        end
        chk("t6_all_idle", 32'(if_c.valid), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
